// File: rtl/dcsa_op_scheduler.sv
// dcsa_op_scheduler: round-robin sequencer for a shared 60-bit duplicated carry-select adder.
// Define DCSA_RETRY_EN to re-issue once when the duplicated sum path disagrees.
`timescale 1ns/1ps

module dcsa_csa60 (
  input  logic [59:0] a,
  input  logic [59:0] b,
  output logic [59:0] s
);
  localparam int BW = 15;
  localparam int NB = 4;

  logic [NB-1:0] c;
  assign c[0] = 1'b0;

  for (genvar k = 0; k < NB; k++) begin : g_blk
    // the top block drops its carry-out, so it is one bit narrower
    localparam int W = (k < NB-1) ? BW+1 : BW;
    logic [W-1:0] s0, s1;
    assign s0 = W'(a[k*BW +: BW]) + W'(b[k*BW +: BW]);
    assign s1 = W'(a[k*BW +: BW]) + W'(b[k*BW +: BW]) + W'(1);
    assign s[k*BW +: BW] = c[k] ? s1[BW-1:0] : s0[BW-1:0];
    if (k < NB-1) begin : g_c
      assign c[k+1] = c[k] ? s1[W-1] : s0[W-1];
    end
  end
endmodule

module dcsa_adder60 (
  input  logic [59:0] a,
  input  logic [59:0] b,
  input  logic        pa,
  input  logic        pb,
  output logic [59:0] s,
  output logic [59:0] s_invert,
  output logic        papb,
  output logic        pab
);
  logic [59:0] s_dup;

  dcsa_csa60 u_main (.a(a), .b(b), .s(s));
  dcsa_csa60 u_dup  (.a(a), .b(b), .s(s_dup));

  assign s_invert = ~s_dup;
  assign papb     = pa ^ pb;
  assign pab      = ^(a ^ b);
endmodule

module dcsa_op_scheduler #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [59:0]      req0_a,
  input  logic [59:0]      req0_b,
  input  logic             req0_pa,
  input  logic             req0_pb,
  input  logic [59:0]      req1_a,
  input  logic [59:0]      req1_b,
  input  logic             req1_pa,
  input  logic             req1_pb,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [59:0]      rsp_sum,
  output logic             rsp_id,
  output logic             rsp_par_err,
  output logic             rsp_dup_err,
  output logic             rsp_retried,
  output logic [CNT_W-1:0] err_count
);
  typedef enum logic [1:0] {IDLE, EXEC, CHECK, RESP} state_t;

  state_t state_q, state_d;
  logic last_grant_q;
  logic gnt, gnt_en;

  logic [59:0] op_a_q, op_b_q;
  logic op_pa_q, op_pb_q, op_id_q;

  logic [59:0] add_s, add_si;
  logic add_papb, add_pab;

  logic [59:0] res_s_q, res_si_q;
  logic res_papb_q, res_pab_q;

  logic par_err, dup_err, retry_go, accept;

  logic [59:0] rsp_sum_q;
  logic rsp_id_q, rsp_par_q, rsp_dup_q;
  logic [CNT_W-1:0] err_cnt_q;

  dcsa_adder60 u_add (
    .a(op_a_q),
    .b(op_b_q),
    .pa(op_pa_q),
    .pb(op_pb_q),
    .s(add_s),
    .s_invert(add_si),
    .papb(add_papb),
    .pab(add_pab)
  );

  assign par_err = res_papb_q != res_pab_q;
  assign dup_err = res_si_q != ~res_s_q;
  assign accept  = (state_q == RESP) & rsp_ready;

`ifdef DCSA_RETRY_EN
  logic retry_q, rsp_ret_q;

  // parity errors come from the operands themselves, so re-issuing cannot help
  assign retry_go = dup_err & ~par_err & ~retry_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_q   <= 1'b0;
      rsp_ret_q <= 1'b0;
    end else begin
      if (gnt_en)
        retry_q <= 1'b0;
      else if (state_q == CHECK && retry_go)
        retry_q <= 1'b1;
      if (state_q == CHECK && !retry_go)
        rsp_ret_q <= retry_q;
    end
  end

  assign rsp_retried = rsp_ret_q;
`else
  assign retry_go    = 1'b0;
  assign rsp_retried = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    gnt       = 1'b0;
    gnt_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid != 2'b00) begin
          gnt = (req_valid == 2'b11) ? ~last_grant_q
                                     : req_valid[1];
          gnt_en    = 1'b1;
          req_ready = gnt ? 2'b10 : 2'b01;
          state_d   = EXEC;
        end
      end
      EXEC:  state_d = CHECK;
      CHECK: state_d = retry_go ? EXEC : RESP;
      RESP:  if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (gnt_en) last_grant_q <= gnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_pa_q    <= 1'b0;
      op_pb_q    <= 1'b0;
      op_id_q    <= 1'b0;
      res_s_q    <= '0;
      res_si_q   <= '0;
      res_papb_q <= 1'b0;
      res_pab_q  <= 1'b0;
      rsp_sum_q  <= '0;
      rsp_id_q   <= 1'b0;
      rsp_par_q  <= 1'b0;
      rsp_dup_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      if (gnt_en) begin
        op_a_q  <= gnt ? req1_a  : req0_a;
        op_b_q  <= gnt ? req1_b  : req0_b;
        op_pa_q <= gnt ? req1_pa : req0_pa;
        op_pb_q <= gnt ? req1_pb : req0_pb;
        op_id_q <= gnt;
      end
      if (state_q == EXEC) begin
        res_s_q    <= add_s;
        res_si_q   <= add_si;
        res_papb_q <= add_papb;
        res_pab_q  <= add_pab;
      end
      if (state_q == CHECK && !retry_go) begin
        rsp_sum_q <= res_s_q;
        rsp_id_q  <= op_id_q;
        rsp_par_q <= par_err;
        rsp_dup_q <= dup_err;
      end
      if (accept && (rsp_par_q | rsp_dup_q) && err_cnt_q != '1)
        err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign rsp_valid   = state_q == RESP;
  assign rsp_sum     = rsp_sum_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_par_err = rsp_par_q;
  assign rsp_dup_err = rsp_dup_q;
  assign err_count   = err_cnt_q;
endmodule

// File: doc/dcsa_op_scheduler.md
# dcsa_op_scheduler

Sequencer and two-port round-robin arbiter for the 60-bit duplicated carry-select adder. It accepts operand pairs with parity bits from two requesters and issues one addition at a time to a single adder instance. It checks operand parity and the duplicated sum path, optionally re-issues once on a duplicate mismatch, and returns a tagged, flagged result over a ready/valid port. It sits between the integer issue logic and the shared protected adder.

## Interface
- CNT_W, 16: width of the saturating error counter.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept; at most one bit high per cycle.
- req0_a, req0_b  in  60  requester 0 operands.
- req0_pa, req0_pb  in  1  requester 0 operand parity (XOR of all bits).
- req1_a, req1_b, req1_pa, req1_pb  in  60/60/1/1  same, requester 1.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accept.
- rsp_sum  out  60  sum (carry-in 0, carry-out dropped).
- rsp_id  out  1  requester index of this result.
- rsp_par_err  out  1  operand parity error.
- rsp_dup_err  out  1  duplicate-path mismatch on the final attempt.
- rsp_retried  out  1  a re-issue occurred.
- err_count  out  CNT_W  saturating count of responses with any error flag.

## Operation
- One adder instance; its inputs are driven only from the operand registers op_a, op_b, op_pa, op_pb.
- States: IDLE, EXEC, CHECK, RESP.
- IDLE: arbitrate among req_valid.
  - Single requester: grant it.
  - Both requesters: grant the one not granted last.
  - last_grant resets to 1, so requester 0 wins the first tie.
  - Grant: req_ready[g]=1 combinationally this cycle, operands and g captured at the edge, last_grant<=g, retry_flag<=0, go EXEC.
  - Nothing valid: stay in IDLE.
- EXEC: register adder outputs s, s_invert, papb, pab into res_s, res_si, res_papb, res_pab; go CHECK.
- CHECK:
  - par_err = res_papb != res_pab.
  - dup_err = res_si != ~res_s (the duplicated path must produce the bitwise complement).
  - If dup_err, not par_err, retry_flag=0, and the retry feature is compiled in: set retry_flag=1 and go EXEC.
  - Otherwise latch the response fields and go RESP.
- RESP: rsp_valid=1 with stable fields until rsp_ready.
  - On accept: go IDLE, and increment err_count (saturating at all-ones) if rsp_par_err or rsp_dup_err.
- A parity error is never retried: the registered operands are unchanged, so a re-issue cannot clear it.
- req_ready is 0 in every state other than IDLE; no new request is accepted while one is in flight.

## Timing
- Reset (asynchronous, any state): state=IDLE, req_ready=0, rsp_valid=0, all rsp_* fields=0, err_count=0, last_grant=1, retry_flag=0. An in-flight operation is discarded with no response.
- Grant handshake at cycle N (req_valid[g] & req_ready[g]).
- No retry: EXEC at N+1, CHECK at N+2, rsp_valid first high at N+3.
- With retry: EXEC at N+3, CHECK at N+4, rsp_valid first high at N+5.
- rsp_valid & rsp_ready at cycle M: the earliest next grant is M+1.
- Throughput: one operation per 4 cycles without backpressure.
- A requester must hold req_valid and its operands until it sees req_ready; deasserting before grant is allowed and simply drops it from arbitration.
- Requests arriving during RESP wait; backpressure on rsp_ready stalls the block indefinitely.

## Configuration
- DCSA_RETRY_EN defined: a single re-issue on dup_err as described; rsp_retried reflects it. The response carries the second attempt's result and flags.
- DCSA_RETRY_EN undefined: CHECK always goes to RESP; rsp_retried is tied to 0; a first-attempt dup_err is reported directly.

## Test plan
- Reset, then req0 only with a=1, b=2, correct parities -> req_ready=2'b01 at N; rsp_valid at N+3 with rsp_sum=3, rsp_id=0, all error flags 0.
- Both requesters held valid for 3 operations -> grant order 0,1,0; rsp_id sequence 0,1,0; at most one req_ready bit ever high.
- req1 with a=60'hFFF_FFFF_FFFF_FFFF, b=1 -> rsp_sum=0 (carry-out dropped), no error flags.
- req0 with pa flipped -> rsp_par_err=1, rsp_retried=0, rsp_valid at N+3; err_count=1 after accept.
- Force the duplicated-path mismatch on the first EXEC only, with DCSA_RETRY_EN defined -> rsp_retried=1, rsp_dup_err=0, rsp_valid at N+5. With it undefined -> rsp_dup_err=1 at N+3.
- Hold rsp_ready=0 for 10 cycles, then assert rst mid-RESP -> rsp fields stable while stalled; after rst: rsp_valid=0, err_count=0, and the next tie grants requester 0.
